start_frame_encoder: RTL and testbench

//  Maple bus pattern transmitter; counterpart to start_frame_decoder.
//  On request, drives SDCKA/SDCKB to emit one of four start patterns or the end pattern.
//  - Start pattern: A low, N pulses on B, A high.
//  - End pattern: B low, two pulses on A, B high.

---
 rtl/maple_pkg.sv | 31 +++
 rtl/phase_timer.sv | 25 ++
 rtl/start_frame_encoder.sv | 119 +++++++++++
 tb/tb_start_frame_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Maple bus pattern constants shared by the start/end pattern encoder and decoder.
package maple_pkg;

    localparam logic [2:0] KIND_FRAME = 3'd0;
    localparam logic [2:0] KIND_CRC   = 3'd1;
    localparam logic [2:0] KIND_OCC   = 3'd2;
    localparam logic [2:0] KIND_RESET = 3'd3;
    localparam logic [2:0] KIND_END   = 3'd4;

    localparam logic [3:0] N_FRAME = 4'd4;
    localparam logic [3:0] N_CRC   = 4'd6;
    localparam logic [3:0] N_OCC   = 4'd8;
    localparam logic [3:0] N_RESET = 4'd14;
    localparam logic [3:0] N_END   = 4'd2;

    function automatic logic kind_legal(input logic [2:0] kind);
        return kind <= KIND_END;
    endfunction

    function automatic logic [3:0] pulse_count(input logic [2:0] kind);
        case (kind)
            KIND_FRAME: return N_FRAME;
            KIND_CRC:   return N_CRC;
            KIND_OCC:   return N_OCC;
            KIND_RESET: return N_RESET;
            KIND_END:   return N_END;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: reloads to PHASE_CYCLES-1 on load, expire is high while at zero.
module phase_timer #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(PHASE_CYCLES - 1);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/start_frame_encoder.sv
// Maple bus start/end pattern transmitter driving SDCKA/SDCKB while a pattern is in flight.
module start_frame_encoder
    import maple_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] kind,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sdcka_out,
    output logic       sdckb_out,
    output logic       sdck_oe
);

    typedef enum logic [3:0] {
        IDLE, S_ALOW, S_BLOW, S_BHIGH, S_ARISE, E_BLOW, E_ALOW, E_AHIGH, E_BRISE
    } state_t;

    state_t     state;
    logic [3:0] pulses;
    logic       expire;
    logic       accept;
    logic       load;

    assign accept = (state == IDLE) && req && kind_legal(kind);
    // Timer restarts on every phase boundary, including the first phase at accept.
    assign load   = accept || ((state != IDLE) && expire);

    phase_timer #(.PHASE_CYCLES(PHASE_CYCLES), .CNT_W(CNT_W)) timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pulses    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sdcka_out <= 1'b1;
            sdckb_out <= 1'b1;
            sdck_oe   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (kind_legal(kind)) begin
                        busy    <= 1'b1;
                        sdck_oe <= 1'b1;
                        pulses  <= pulse_count(kind);
                        if (kind == KIND_END) begin
                            state     <= E_BLOW;
                            sdckb_out <= 1'b0;
                        end else begin
                            state     <= S_ALOW;
                            sdcka_out <= 1'b0;
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
                S_ALOW: if (expire) begin
                    state     <= S_BLOW;
                    sdckb_out <= 1'b0;
                end
                S_BLOW: if (expire) begin
                    state     <= S_BHIGH;
                    sdckb_out <= 1'b1;
                end
                S_BHIGH: if (expire) begin
                    pulses <= pulses - 4'd1;
                    if (pulses != 4'd1) begin
                        state     <= S_BLOW;
                        sdckb_out <= 1'b0;
                    end else begin
                        state     <= S_ARISE;
                        sdcka_out <= 1'b1;
                    end
                end
                E_BLOW: if (expire) begin
                    state     <= E_ALOW;
                    sdcka_out <= 1'b0;
                end
                E_ALOW: if (expire) begin
                    state     <= E_AHIGH;
                    sdcka_out <= 1'b1;
                end
                E_AHIGH: if (expire) begin
                    pulses <= pulses - 4'd1;
                    if (pulses != 4'd1) begin
                        state     <= E_ALOW;
                        sdcka_out <= 1'b0;
                    end else begin
                        state     <= E_BRISE;
                        sdckb_out <= 1'b1;
                    end
                end
                // Both lines are already high here; finishing just releases the bus.
                S_ARISE, E_BRISE: if (expire) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sdck_oe <= 1'b0;
                    done    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_start_frame_encoder.sv
// Scoreboard bench: a phase-list model expands each accepted request into per-cycle line levels.
module tb_start_frame_encoder;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic [2:0] kind = 3'd0;
    logic       busy, done, err, sdcka_out, sdckb_out, sdck_oe;

    start_frame_encoder #(.PHASE_CYCLES(P), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .kind      (kind),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sdcka_out (sdcka_out),
        .sdckb_out (sdckb_out),
        .sdck_oe   (sdck_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int typ;   // 0 busy cycle, 1 done pulse, 2 err pulse
        bit a;
        bit b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   left = 0;
    int   n_done = 0, n_starts = 0, n_idle = 0;
    int   cur_len = 0, cur_bf = 0, cur_af = 0;
    int   last_len = 0, last_bf = 0, last_af = 0;
    bit   prev_busy = 0, pa = 1, pb = 1;
    logic [5:0] v, ev;
    exp_t e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic push_phase(input bit a, input bit b);
        exp_t x;
        x.typ = 0; x.a = a; x.b = b;
        repeat (P) exp_q.push_back(x);
    endtask

    // Start: A low, N B pulses, A high. End: B low, two A pulses, B high.
    task automatic push_pattern(input int k, output int n);
        int s, np;
        s = exp_q.size();
        if (k == 4) begin
            push_phase(1, 0);
            repeat (2) begin push_phase(0, 0); push_phase(1, 0); end
            push_phase(1, 1);
        end else begin
            np = (k == 0) ? 4 : (k == 1) ? 6 : (k == 2) ? 8 : 14;
            push_phase(0, 1);
            repeat (np) begin push_phase(0, 0); push_phase(0, 1); end
            push_phase(1, 1);
        end
        n = exp_q.size() - s;
    endtask

    // Reference model: decides acceptance from its own notion of busy time.
    always @(posedge clk) begin
        exp_t x;
        int n;
        if (!reset) begin
            exp_q.delete();
            left = 0;
        end else if (left == 0) begin
            if (req) begin
                if (kind <= 3'd4) begin
                    push_pattern(int'(kind), n);
                    left = n;
                end else begin
                    x.typ = 2; x.a = 1; x.b = 1;
                    exp_q.push_back(x);
                end
            end
        end else begin
            left--;
            if (left == 0) begin
                x.typ = 1; x.a = 1; x.b = 1;
                exp_q.push_back(x);
            end
        end
    end

    // Monitor: one scoreboard entry per non-idle cycle, plus pattern statistics.
    always @(negedge clk) begin
        v = {busy, done, err, sdck_oe, sdcka_out, sdckb_out};
        if (!reset) begin
            chk("reset_values", 32'(v), 32'(6'b000011));
            cur_len = 0; cur_bf = 0; cur_af = 0;
            prev_busy = 0; pa = 1; pb = 1;
        end else begin
            if (busy && !prev_busy) n_starts++;
            if (busy) begin
                cur_len++;
                if (pb && !sdckb_out) cur_bf++;
                if (pa && !sdcka_out) cur_af++;
            end
            if (done) begin
                last_len = cur_len; last_bf = cur_bf; last_af = cur_af;
                cur_len = 0; cur_bf = 0; cur_af = 0;
                n_done++;
            end
            if (!busy && !done && !err) n_idle++;
            if (busy || done || err || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(v), 32'(6'b000011));
                end else begin
                    e = exp_q.pop_front();
                    case (e.typ)
                        0:       ev = {3'b100, 1'b1, e.a, e.b};
                        1:       ev = 6'b010011;
                        default: ev = 6'b001011;
                    endcase
                    chk("scoreboard", 32'(v), 32'(ev));
                end
            end else begin
                chk("idle_level", 32'(v), 32'(6'b000011));
            end
            prev_busy = busy; pa = sdcka_out; pb = sdckb_out;
        end
    end

    task automatic issue(input logic [2:0] k);
        @(posedge clk); #2;
        req = 1'b1; kind = k;
        @(posedge clk); #2;
        req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (n_done >= target) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_busy();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1; break; end
        end
        chk("busy_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int n0, s0, i0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Frame start: 4 B pulses, (2*4+2)*P busy cycles.
        n0 = n_done;
        issue(3'd0);
        wait_done(n0 + 1);
        chk("frame_len", 32'(last_len), 32'd20);
        chk("frame_bfalls", 32'(last_bf), 32'd4);
        chk("frame_done_count", 32'(n_done), 32'(n0 + 1));

        // CRC, occupancy, reset starts back-to-back with req held.
        n0 = n_done; s0 = n_starts;
        @(posedge clk); #2;
        req = 1'b1; kind = 3'd1;
        wait_busy();
        i0 = n_idle;
        kind = 3'd2;
        wait_done(n0 + 1);
        chk("b2b_crc_bfalls", 32'(last_bf), 32'd6);
        kind = 3'd3;
        wait_done(n0 + 2);
        chk("b2b_occ_bfalls", 32'(last_bf), 32'd8);
        req = 1'b0;
        wait_done(n0 + 3);
        chk("b2b_reset_bfalls", 32'(last_bf), 32'd14);
        chk("b2b_reset_len", 32'(last_len), 32'(30 * P));
        chk("b2b_idle_gap", 32'(n_idle - i0), 32'd0);
        chk("b2b_starts", 32'(n_starts - s0), 32'd3);

        // End pattern: 6*P cycles, A falls twice, B falls once.
        n0 = n_done;
        issue(3'd4);
        wait_done(n0 + 1);
        chk("end_len", 32'(last_len), 32'(6 * P));
        chk("end_afalls", 32'(last_af), 32'd2);
        chk("end_bfalls", 32'(last_bf), 32'd1);

        // Illegal kind: err pulse only, bus untouched.
        @(posedge clk); #2;
        req = 1'b1; kind = 3'd6;
        @(posedge clk); #1;
        req = 1'b0;
        chk("illegal_err", 32'({err, busy, sdck_oe}), 32'(3'b100));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("illegal_quiet", 32'({busy, done, err, sdck_oe, sdcka_out, sdckb_out}), 32'(6'b000011));
        end

        // Reset during the third B-low phase of a reset start.
        n0 = n_done;
        issue(3'd3);
        repeat (11) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("abort_release", 32'({busy, done, err, sdck_oe, sdcka_out, sdckb_out}), 32'(6'b000011));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        chk("abort_no_done", 32'(n_done), 32'(n0));
        issue(3'd0);
        wait_done(n0 + 1);
        chk("after_abort_len", 32'(last_len), 32'd20);
        chk("after_abort_bfalls", 32'(last_bf), 32'd4);

        // req and kind churn while busy must not alter the running pattern.
        n0 = n_done; s0 = n_starts;
        @(posedge clk); #2;
        req = 1'b1; kind = 3'd2;
        wait_busy();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            req = 1'($urandom);
            kind = 3'($urandom);
        end
        req = 1'b0;
        wait_done(n0 + 1);
        repeat (6) @(posedge clk);
        #1;
        chk("churn_len", 32'(last_len), 32'(18 * P));
        chk("churn_bfalls", 32'(last_bf), 32'd8);
        chk("churn_starts", 32'(n_starts - s0), 32'd1);
        chk("churn_dones", 32'(n_done - n0), 32'd1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #2;
            req = ($urandom_range(0, 2) == 0);
            kind = 3'($urandom);
        end
        req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        repeat (2) @(posedge clk);
        #1 chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
